// File: rtl/mips_shift_pipe.sv
// mips_shift_pipe: pipelined MIPS shifter (in_valid/in_ready ops with funct, shamt, rs, rt, tag; out_valid/out_ready result, tag, illegal flag; flush)
module mips_shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_funct,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [WIDTH-1:0]         in_rs,
  input  logic [WIDTH-1:0]         in_rt,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_illegal
);
  localparam int SW = $clog2(WIDTH);
  localparam int K  = (SW + STAGES - 1) / STAGES;
  logic             legal, stall, unused_ok;
  logic             sv [STAGES], v_q [STAGES], si [STAGES], i_q [STAGES];
  logic [WIDTH-1:0] sd [STAGES], d_q [STAGES];
  logic [SW-1:0]    sa [STAGES], a_q [STAGES];
  logic [1:0]       sm [STAGES], m_q [STAGES];
  logic [TAG_W-1:0] st [STAGES], t_q [STAGES];
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [SW-1:0] a,
                                            input logic [1:0] m, input int j);
    logic [WIDTH-1:0] r;
    r = d;
    for (int b = 0; b < SW; b++)
      if (b / K == j && a[b]) begin
        if (m[1]) r = r << (1 << b);
        else if (m[0]) r = $signed(r) >>> (1 << b);
        else r = r >> (1 << b);
      end
    return r;
  endfunction
  assign legal     = in_funct[5:3] == 3'b000 && in_funct[1:0] != 2'b01;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign unused_ok = ^{in_rs[WIDTH-1:SW], a_q[STAGES-1], m_q[STAGES-1]};
  always_comb begin
    sv[0] = in_valid;
    sd[0] = legal ? in_rt : '0;
    sa[0] = in_funct[2] ? in_rs[SW-1:0] : in_shamt;
    sm[0] = {in_funct[1:0] == 2'b00, in_funct[1:0] == 2'b11};
    st[0] = in_tag;
    si[0] = !legal;
    for (int j = 1; j < STAGES; j++) begin
      sv[j] = v_q[j-1];
      sd[j] = d_q[j-1];
      sa[j] = a_q[j-1];
      sm[j] = m_q[j-1];
      st[j] = t_q[j-1];
      si[j] = i_q[j-1];
    end
  end
  always_ff @(posedge clk)
    if (reset)
      for (int j = 0; j < STAGES; j++) begin
        v_q[j] <= 1'b0;
        d_q[j] <= '0;
        a_q[j] <= '0;
        m_q[j] <= '0;
        t_q[j] <= '0;
        i_q[j] <= 1'b0;
      end
    else if (flush)
      for (int j = 0; j < STAGES; j++) v_q[j] <= 1'b0;
    else if (!stall)
      for (int j = 0; j < STAGES; j++) begin
        v_q[j] <= sv[j];
        d_q[j] <= step(sd[j], sa[j], sm[j], j);
        a_q[j] <= sa[j];
        m_q[j] <= sm[j];
        t_q[j] <= st[j];
        i_q[j] <= si[j];
      end
  assign out_valid   = v_q[STAGES-1];
  assign out_result  = d_q[STAGES-1];
  assign out_tag     = t_q[STAGES-1];
  assign out_illegal = i_q[STAGES-1];
endmodule

// File: tb/tb_mips_shift_pipe.sv
// tb_mips_shift_pipe: directed self-checking bench for mips_shift_pipe plus parameter sweeps
module tb_mips_shift_pipe;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt, in_tag, out_tag;
  logic [31:0] in_rs, in_rt, out_result;
  logic        s_valid;
  logic [5:0]  s_funct, s_amt;
  logic [4:0]  s_tag;
  logic [63:0] s_rs, s_rt;
  logic        a_rdy, a_ov, a_ill, b_rdy, b_ov, b_ill, c_rdy, c_ov, c_ill;
  logic [15:0] a_res, b_res;
  logic [63:0] c_res;
  logic [4:0]  a_tag, b_tag, c_tag;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  mips_shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_illegal(out_illegal));
  mips_shift_pipe #(.WIDTH(16), .STAGES(1), .TAG_W(5)) dut_a (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(a_rdy), .in_funct(s_funct),
    .in_shamt(s_amt[3:0]), .in_rs(s_rs[15:0]), .in_rt(s_rt[15:0]), .in_tag(s_tag), .flush(1'b0),
    .out_valid(a_ov), .out_ready(1'b1), .out_result(a_res), .out_tag(a_tag), .out_illegal(a_ill));
  mips_shift_pipe #(.WIDTH(16), .STAGES(4), .TAG_W(5)) dut_b (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(b_rdy), .in_funct(s_funct),
    .in_shamt(s_amt[3:0]), .in_rs(s_rs[15:0]), .in_rt(s_rt[15:0]), .in_tag(s_tag), .flush(1'b0),
    .out_valid(b_ov), .out_ready(1'b1), .out_result(b_res), .out_tag(b_tag), .out_illegal(b_ill));
  mips_shift_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(5)) dut_c (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(c_rdy), .in_funct(s_funct),
    .in_shamt(s_amt), .in_rs(s_rs), .in_rt(s_rt), .in_tag(s_tag), .flush(1'b0),
    .out_valid(c_ov), .out_ready(1'b1), .out_result(c_res), .out_tag(c_tag), .out_illegal(c_ill));
  function automatic logic [63:0] ref_shift(input logic [5:0] f, input logic [63:0] rt, input logic [63:0] rs,
                                            input logic [5:0] sh, input int w);
    logic [63:0] mask, x, r;
    int amt;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    amt  = int'(f[2] ? rs[5:0] : sh) & (w - 1);
    x    = rt & mask;
    if (f == 6'd0 || f == 6'd4) r = (x << amt) & mask;
    else if (f == 6'd2 || f == 6'd6) r = x >> amt;
    else r = (x >> amt) | (x[w-1] ? (mask & ~(mask >> amt)) : 64'd0);
    return r;
  endfunction
  task automatic send(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] tg);
    logic acc;
    acc      = 1'b0;
    in_funct = f;
    in_shamt = sh;
    in_rs    = rs;
    in_rt    = rt;
    in_tag   = tg;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_accept tag=%0d in_ready stayed 0, required 1", tg);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; s_valid = 1'b0;
    in_funct = '0; in_shamt = '0; in_rs = '0; in_rt = '0; in_tag = '0;
    s_funct = '0; s_amt = '0; s_rs = '0; s_rt = '0; s_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({out_valid, in_ready, out_illegal} !== 3'b010) begin
      errors++;
      $display("FAIL reset_flags valid/ready/illegal=%b required 010", {out_valid, in_ready, out_illegal});
    end
    checks++;
    if (out_result !== 32'h0 || out_tag !== 5'h0) begin
      errors++;
      $display("FAIL reset_data result=%h tag=%h required 0/0", out_result, out_tag);
    end
    checks++;
    if ({a_ov, b_ov, c_ov} !== 3'b000) begin
      errors++;
      $display("FAIL reset_sweep_valid got %b required 000", {a_ov, b_ov, c_ov});
    end
  endtask
  task automatic test_shift;
    logic [5:0]  vf [6];
    logic [4:0]  vs [6];
    logic [31:0] vr [6], vt [6], ve [6];
    vf = '{6'd7, 6'd6, 6'd0, 6'd3, 6'd4, 6'd2};
    vs = '{5'd0, 5'd0, 5'd31, 5'd0, 5'd0, 5'd4};
    vr = '{32'h24, 32'h24, 32'h0, 32'h0, 32'hFFFFFFE8, 32'h0};
    vt = '{32'h80000000, 32'h80000000, 32'h1, 32'h12345678, 32'h0000FFFF, 32'hF0000000};
    ve = '{32'hF8000000, 32'h08000000, 32'h80000000, 32'h12345678, 32'h00FFFF00, 32'h0F000000};
    for (int i = 0; i < 6; i++) begin
      send(vf[i], vs[i], vr[i], vt[i], 5'(i + 1));
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL shift_early vec=%0d out_valid=%b required 0", i, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_illegal, out_tag, out_result} !== {1'b1, 1'b0, 5'(i + 1), ve[i]}) begin
        errors++;
        $display("FAIL shift_result vec=%0d valid=%b ill=%b tag=%0d result=%h required 1/0/%0d/%h",
                 i, out_valid, out_illegal, out_tag, out_result, i + 1, ve[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_illegal;
    send(6'h20, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd9);
    send(6'h00, 5'd1, 32'h0, 32'h3, 5'd10);
    checks++;
    if ({out_valid, out_illegal, out_tag, out_result} !== {1'b1, 1'b1, 5'd9, 32'h0}) begin
      errors++;
      $display("FAIL illegal_op valid=%b ill=%b tag=%0d result=%h required 1/1/9/00000000",
               out_valid, out_illegal, out_tag, out_result);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_illegal, out_tag, out_result} !== {1'b1, 1'b0, 5'd10, 32'h6}) begin
      errors++;
      $display("FAIL illegal_next valid=%b ill=%b tag=%0d result=%h required 1/0/10/00000006",
               out_valid, out_illegal, out_tag, out_result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_drain out_valid=%b required 0", out_valid);
    end
  endtask
  task automatic test_back_to_back;
    out_ready = 1'b0;
    send(6'h00, 5'd1, 32'h0, 32'h1, 5'd1);
    send(6'h00, 5'd2, 32'h0, 32'h2, 5'd2);
    in_funct = 6'h00; in_shamt = 5'd3; in_rt = 32'h3; in_tag = 5'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready, out_valid, out_illegal, out_tag, out_result} !== {1'b0, 1'b1, 1'b0, 5'd1, 32'h2}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d ready=%b valid=%b ill=%b tag=%0d result=%h required 0/1/0/1/00000002",
                 i, in_ready, out_valid, out_illegal, out_tag, out_result);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 5'd2, 32'h8}) begin
      errors++;
      $display("FAIL order_2 valid=%b tag=%0d result=%h required 1/2/00000008", out_valid, out_tag, out_result);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 5'd3, 32'h18}) begin
      errors++;
      $display("FAIL order_3 valid=%b tag=%0d result=%h required 1/3/00000018", out_valid, out_tag, out_result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_drain out_valid=%b required 0", out_valid);
    end
  endtask
  task automatic test_flush_reset;
    send(6'h00, 5'd1, 32'h0, 32'h1, 5'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid, in_ready, out_tag, out_result} !== {1'b0, 1'b1, 5'd0, 32'h0}) begin
        errors++;
        $display("FAIL reset_inflight cyc=%0d valid=%b ready=%b tag=%0d result=%h required 0/1/0/00000000",
                 i, out_valid, in_ready, out_tag, out_result);
      end
      @(posedge clk);
      #1;
    end
    send(6'h00, 5'd1, 32'h0, 32'h1, 5'd5);
    flush = 1'b1;
    in_funct = 6'h00; in_shamt = 5'd1; in_rt = 32'h7; in_tag = 5'd6; in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL flush_inflight cyc=%0d valid=%b ready=%b required 0/1", i, out_valid, in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    send(6'h00, 5'd1, 32'h0, 32'h1, 5'd7);
    send(6'h00, 5'd1, 32'h0, 32'h2, 5'd8);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL flush_stall cyc=%0d valid=%b ready=%b required 0/1", i, out_valid, in_ready);
      end
      @(posedge clk);
      #1;
    end
    send(6'h00, 5'd1, 32'h0, 32'h1, 5'd9);
    @(posedge clk);
    #1;
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    checks++;
    if ({out_valid, out_tag, out_result} !== {1'b0, 5'd0, 32'h0}) begin
      errors++;
      $display("FAIL flush_and_reset valid=%b tag=%0d result=%h required 0/0/00000000", out_valid, out_tag, out_result);
    end
    out_ready = 1'b1;
  endtask
  task automatic test_sweep;
    logic [5:0]  ops [6];
    logic [63:0] ea, eb, ec;
    ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
    for (int i = 0; i < 6; i++)
      for (int amt = 0; amt < 64; amt++) begin
        s_rt    = {$urandom(), $urandom()};
        s_rs    = {$urandom(), $urandom()};
        s_funct = ops[i];
        s_amt   = 6'(amt);
        s_tag   = 5'(amt);
        if (ops[i][2]) s_rs[5:0] = 6'(amt);
        ea = ref_shift(ops[i], s_rt, s_rs, s_amt, 16);
        eb = ea;
        ec = ref_shift(ops[i], s_rt, s_rs, s_amt, 64);
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          checks++;
          if (a_ov !== (k == 1) || a_rdy !== 1'b1 || (k == 1 && {a_ill, a_tag, a_res} !== {1'b0, s_tag, ea[15:0]})) begin
            errors++;
            $display("FAIL sweep16s1 f=%0d amt=%0d k=%0d valid=%b result=%h required %h at k=1",
                     ops[i], amt, k, a_ov, a_res, ea[15:0]);
          end
          checks++;
          if (b_ov !== (k == 4) || b_rdy !== 1'b1 || (k == 4 && {b_ill, b_tag, b_res} !== {1'b0, s_tag, eb[15:0]})) begin
            errors++;
            $display("FAIL sweep16s4 f=%0d amt=%0d k=%0d valid=%b result=%h required %h at k=4",
                     ops[i], amt, k, b_ov, b_res, eb[15:0]);
          end
          checks++;
          if (c_ov !== (k == 3) || c_rdy !== 1'b1 || (k == 3 && {c_ill, c_tag, c_res} !== {1'b0, s_tag, ec})) begin
            errors++;
            $display("FAIL sweep64s3 f=%0d amt=%0d k=%0d valid=%b result=%h required %h at k=3",
                     ops[i], amt, k, c_ov, c_res, ec);
          end
          if (k < 4) begin
            @(posedge clk);
            #1;
          end
        end
      end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required finish before 500000");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_shift;
    test_illegal;
    test_back_to_back;
    test_flush_reset;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_shift_pipe.md
MIPS_SHIFT_PIPE -- requirements
Module: mips_shift_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have parameter STAGES, default 2, giving the pipeline depth; legal range is 1..SW, where SW = $clog2(WIDTH).
REQ-003 The block SHALL have parameter TAG_W, default 5, giving the width of the destination-register tag carried alongside each operation.
REQ-004 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  Reset SHALL be synchronous and active-high.
REQ-006 in_valid  input  1  Operation offered this cycle.
REQ-007 in_ready  output  1  Block accepts the offered operation this cycle.
REQ-008 in_funct  input  6  MIPS R-type funct field.
REQ-009 in_shamt  input  SW  Immediate shift amount.
REQ-010 in_rs  input  WIDTH  Variable shift-amount source.
REQ-011 in_rt  input  WIDTH  Operand to be shifted.
REQ-012 in_tag  input  TAG_W  Destination tag, returned unchanged.
REQ-013 flush  input  1  Discard all in-flight operations.
REQ-014 out_valid  output  1  Result available.
REQ-015 out_ready  input  1  Consumer accepts the result.
REQ-016 out_result  output  WIDTH  Shift result.
REQ-017 out_tag  output  TAG_W  Tag of the result.
REQ-018 out_illegal  output  1  Operation carried an unsupported funct.

Function
REQ-019 Decoding SHALL be: 000000 SLL, 000010 SRL, 000011 SRA use in_shamt; 000100 SLLV, 000110 SRLV, 000111 SRAV use in_rs[SW-1:0]; every other funct is illegal.
REQ-020 Arithmetic SHALL be: SLL/SLLV give rt<<amt; SRL/SRLV give a logical rt>>amt; SRA/SRAV give rt shifted right by amt with sign fill from rt[WIDTH-1]. An amount of 0 SHALL pass rt through unchanged.
REQ-021 In the variable forms, bits of in_rs above SW-1 SHALL be ignored (for example, rs=0x24 with WIDTH=32 gives a shift of 4).
REQ-022 The shift SHALL be decomposed into power-of-two steps. Each amount bit SHALL be applied in exactly one stage, in low-to-high bit order. Stage j SHALL apply bits [j*K, min((j+1)*K, SW)-1], where K = ceil(SW/STAGES).
REQ-023 Each stage SHALL register its valid bit, partial result, remaining amount bits, direction/sign mode, tag and illegal flag.
REQ-024 An operation SHALL be accepted when in_valid && in_ready are both high at a rising edge.
REQ-025 When not stalled, out_valid SHALL assert exactly STAGES cycles after acceptance.
REQ-026 Sustained throughput SHALL be one operation per cycle.
REQ-027 Stall SHALL be defined as out_valid && !out_ready. While stalled, every stage SHALL hold its contents.
REQ-028 in_ready SHALL equal !stall, driven combinationally from out_valid and out_ready only.
REQ-029 Results SHALL leave in acceptance order; no operation SHALL be dropped or duplicated, and pipeline bubbles SHALL be preserved.
REQ-030 out_result, out_tag and out_illegal SHALL remain stable while out_valid=1 and out_ready=0.
REQ-031 An illegal operation SHALL flow through with normal latency, with out_illegal=1 and out_result=0.
REQ-032 flush SHALL clear every stage valid bit at the next edge, overriding stall. An operation offered in the same cycle SHALL NOT be accepted.
REQ-033 Simultaneous flush and reset SHALL behave as reset.

Reset
REQ-034 While reset=1, all stage valid bits SHALL clear at the edge. Afterwards out_valid=0, in_ready=1, out_result=0, out_tag=0 and out_illegal=0.
REQ-035 Reset SHALL discard in-flight operations and SHALL take effect regardless of stall.
REQ-036 Datapath registers other than the outputs need not be reset.

Verification
REQ-037 SRAV, rt=0x80000000, rs=0x00000024 -> out_result=0xF8000000 after 2 cycles, out_illegal=0.
REQ-038 SRLV, rt=0x80000000, rs=0x00000024 -> 0x08000000; SLL, rt=0x00000001, shamt=31 -> 0x80000000; SRA, rt=0x12345678, shamt=0 -> 0x12345678.
REQ-039 Backpressure: three back-to-back ops with tags 1, 2 and 3, out_ready=0 for 5 cycles, then 1 -> in_ready=0 while stalled; outputs held stable; tags emerge 1, 2, 3 on consecutive cycles.
REQ-040 funct=0x20, rt=0xFFFFFFFF -> out_illegal=1 and out_result=0 at latency 2; the following legal op is unaffected.
REQ-041 Reset asserted one cycle after accepting an op -> out_valid stays 0 and in_ready=1 on the cycle after reset deasserts; the same applies to flush.
REQ-042 Sweep WIDTH=16 with STAGES=1 and STAGES=4, and WIDTH=64 with STAGES=3, over all 6 ops and all amounts on random rt -> each result matches the reference shift model; latency equals STAGES.
